// File: rtl/requant_unit.sv
// requant_unit: converts 4-lane int32 accumulators from the matrix engine's
// result buffer into packed int8 values. The per-lane flow is: add the bias,
// apply a left shift, multiply by a fixed-point multiplier with rounding,
// apply a rounding right shift, add the output offset, then clamp.
// The pipeline has four arithmetic stages followed by an output register,
// under one global stall enable.
module requant_unit #(
  parameter int LANES    = 4,
  parameter int ACC_BITS = 32,
  parameter int OUT_BITS = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cfg_wr,
  input  logic [2:0]                cfg_addr,
  input  logic [31:0]               cfg_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*ACC_BITS-1:0] in_acc,
  input  logic [LANES*ACC_BITS-1:0] in_bias,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*OUT_BITS-1:0] out_data,
  output logic                      busy
);

  localparam int W  = ACC_BITS;
  localparam int PW = 2 * ACC_BITS;

  localparam logic signed [W-1:0]  ACC_MIN   = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [W-1:0]  ACC_MAX   = {1'b0, {(W-1){1'b1}}};
  // Rounding nudges used by the doubling high-mul: +2^(W-2) or 1-2^(W-2).
  localparam logic signed [PW-1:0] NUDGE_POS = PW'(1) << (W - 2);
  localparam logic signed [PW-1:0] NUDGE_NEG = PW'(1) - NUDGE_POS;
  // Bias added to negative sums so that the shift truncates toward zero.
  localparam logic signed [PW-1:0] TRUNC_ADJ = (PW'(1) << (W - 1)) - PW'(1);

  // Reset values of the config registers. Together they give an identity
  // transform for values that are already in int8 range.
  localparam logic signed [W-1:0]        MULT_RST   = W'(32'h4000_0000);
  localparam logic signed [5:0]          SHIFT_RST  = 6'sd1;
  localparam logic signed [OUT_BITS-1:0] ACTMIN_RST = {1'b1, {(OUT_BITS-1){1'b0}}};
  localparam logic signed [OUT_BITS-1:0] ACTMAX_RST = {1'b0, {(OUT_BITS-1){1'b1}}};

  // ---------------------------------------------------------------------------
  // Lane arithmetic helpers
  // ---------------------------------------------------------------------------

  // Stage 1: add the bias (with wraparound), then apply a left shift when the
  // shift value is positive.
  function automatic logic signed [W-1:0] bias_shift(
    input logic signed [W-1:0] acc,
    input logic signed [W-1:0] bias,
    input logic        [5:0]   shift
  );
    logic signed [W-1:0] sum;
    logic        [4:0]   lsh;
    sum = acc + bias;
    lsh = shift[5] ? 5'd0 : shift[4:0];
    bias_shift = sum << lsh;
  endfunction

  // Stage 3a: saturating rounding doubling high-mul. The only case that can
  // overflow (MIN * MIN) is flagged one stage earlier and saturates here.
  function automatic logic signed [W-1:0] high_mul(
    input logic signed [PW-1:0] p,
    input logic                 sat
  );
    logic signed [PW-1:0] s;
    s = p + (p[PW-1] ? NUDGE_NEG : NUDGE_POS);
    if (s[PW-1]) begin
      s = s + TRUNC_ADJ;
    end
    high_mul = sat ? ACC_MAX : s[PW-2:W-1];
  endfunction

  // Stage 3b: divide by 2^e with rounding; ties round away from zero.
  function automatic logic signed [W-1:0] round_div(
    input logic signed [W-1:0] h,
    input logic        [5:0]   e
  );
    logic        [W-1:0] mask;
    logic        [W-1:0] rem;
    logic        [W-1:0] thr;
    logic signed [W-1:0] q;
    mask = (W'(1) << e) - W'(1);
    rem  = h & mask;
    thr  = (mask >> 1) + W'(h[W-1]);
    q    = h >>> e;
    round_div = q + $signed(W'(rem > thr));
  endfunction

  // Stage 4: add the offset with saturation, then clamp. The max is applied
  // before the min, so a reversed window (act_min > act_max) returns act_max.
  function automatic logic [OUT_BITS-1:0] offset_clamp(
    input logic signed [W-1:0]        r,
    input logic signed [W-1:0]        off,
    input logic signed [OUT_BITS-1:0] lo8,
    input logic signed [OUT_BITS-1:0] hi8
  );
    logic signed [W:0]   sum;
    logic signed [W-1:0] y;
    logic signed [W-1:0] lo;
    logic signed [W-1:0] hi;
    logic signed [W-1:0] t;
    sum = {r[W-1], r} + {off[W-1], off};
    if (sum[W] != sum[W-1]) begin
      y = sum[W] ? ACC_MIN : ACC_MAX;
    end else begin
      y = sum[W-1:0];
    end
    lo = {{(W-OUT_BITS){lo8[OUT_BITS-1]}}, lo8};
    hi = {{(W-OUT_BITS){hi8[OUT_BITS-1]}}, hi8};
    t  = (y < lo) ? lo : y;
    t  = (t > hi) ? hi : t;
    offset_clamp = t[OUT_BITS-1:0];
  endfunction

  // ---------------------------------------------------------------------------
  // Configuration registers
  // ---------------------------------------------------------------------------
  logic signed [W-1:0]        mult_q;
  logic signed [5:0]          shift_q;
  logic signed [W-1:0]        offset_q;
  logic signed [OUT_BITS-1:0] act_min_q;
  logic signed [OUT_BITS-1:0] act_max_q;
  logic        [5:0]          rshift;

  // Config write port. It accepts writes in any cycle, independent of the data path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mult_q    <= MULT_RST;
      shift_q   <= SHIFT_RST;
      offset_q  <= '0;
      act_min_q <= ACTMIN_RST;
      act_max_q <= ACTMAX_RST;
    end else if (cfg_wr) begin
      case (cfg_addr)
        3'd0:    mult_q    <= cfg_data[W-1:0];
        3'd1:    shift_q   <= cfg_data[5:0];
        3'd2:    offset_q  <= cfg_data[W-1:0];
        3'd3:    act_min_q <= cfg_data[OUT_BITS-1:0];
        3'd4:    act_max_q <= cfg_data[OUT_BITS-1:0];
        default: ;
      endcase
    end
  end

  // A negative shift becomes a rounding right shift by its magnitude.
  assign rshift = shift_q[5] ? (6'd0 - shift_q) : 6'd0;

  // ---------------------------------------------------------------------------
  // Pipeline control: one enable freezes every stage while the output is held
  // ---------------------------------------------------------------------------
  logic                      en;
  logic                      v1_q, v2_q, v3_q, v4_q;
  logic                      out_valid_q;
  logic [LANES*OUT_BITS-1:0] out_data_d;
  logic [LANES*OUT_BITS-1:0] out_data_q;

  assign en       = !out_valid_q || out_ready;
  assign in_ready = en;

  // Valid bits and output register. Bubbles travel with the data and are not collapsed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      v3_q        <= 1'b0;
      v4_q        <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (en) begin
      v1_q        <= in_valid;
      v2_q        <= v1_q;
      v3_q        <= v2_q;
      v4_q        <= v3_q;
      out_valid_q <= v4_q;
      out_data_q  <= out_data_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-lane datapath. Lane 0 sits in the most significant slice on both sides.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    localparam int ALSB = (LANES - 1 - gi) * W;
    localparam int OLSB = (LANES - 1 - gi) * OUT_BITS;

    logic signed [W-1:0]  acc_l;
    logic signed [W-1:0]  bias_l;
    logic signed [W-1:0]  x_d, x_q;
    logic signed [PW-1:0] p_d, p_q;
    logic                 sat_d, sat_q;
    logic signed [W-1:0]  h_d, h_q;
    logic signed [W-1:0]  r_d, r_q;

    assign acc_l  = in_acc[ALSB +: W];
    assign bias_l = in_bias[ALSB +: W];

    assign x_d   = bias_shift(acc_l, bias_l, shift_q);
    assign p_d   = PW'(x_q) * PW'(mult_q);
    assign sat_d = (x_q == ACC_MIN) && (mult_q == ACC_MIN);
    assign h_d   = round_div(high_mul(p_q, sat_q), 6'd0);
    assign r_d   = round_div(h_q, rshift);

    assign out_data_d[OLSB +: OUT_BITS] = offset_clamp(r_q, offset_q, act_min_q, act_max_q);

    // Lane stage registers: biased/shifted value, product, high half, rounded result.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        x_q   <= '0;
        p_q   <= '0;
        sat_q <= 1'b0;
        h_q   <= '0;
        r_q   <= '0;
      end else if (en) begin
        x_q   <= x_d;
        p_q   <= p_d;
        sat_q <= sat_d;
        h_q   <= h_d;
        r_q   <= r_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = v1_q | v2_q | v3_q | v4_q | out_valid_q;

endmodule
